// File: rtl/crc_param_faulty_memory_if.sv
// crc_param_faulty_memory_if: request, fault-injection and result bundle of the CRC-protected memory
interface crc_param_faulty_memory_if #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int CRC_W     = 4,
  parameter int MAX_BURST = 4
);
  localparam int CW = DATA_W + CRC_W;
  logic                             wr_req;
  logic                             rd_req;
  logic [ADDR_W-1:0]                addr_in;
  logic [DATA_W-1:0]                data_in;
  logic                             fault_en;
  logic [$clog2(CW)-1:0]            fault_pos;
  logic [$clog2(MAX_BURST+1)-1:0]   burst_len;
  logic                             busy;
  logic                             done;
  logic [DATA_W-1:0]                rd_data;
  logic                             data_valid;
  logic                             error_detected;
  logic [7:0]                       err_count;
  logic [ADDR_W-1:0]                last_err_addr;
  modport master (
    output wr_req, rd_req, addr_in, data_in, fault_en, fault_pos, burst_len,
    input  busy, done, rd_data, data_valid, error_detected, err_count, last_err_addr
  );
  modport slave (
    input  wr_req, rd_req, addr_in, data_in, fault_en, fault_pos, burst_len,
    output busy, done, rd_data, data_valid, error_detected, err_count, last_err_addr
  );
endinterface

// File: rtl/crc_param_faulty_memory.sv
// crc_param_faulty_memory: CRC-protected memory with bit-serial encode/check and read-path burst injection
module crc_param_faulty_memory #(
  parameter int               DATA_W    = 8,
  parameter int               ADDR_W    = 4,
  parameter int               CRC_W     = 4,
  parameter logic [CRC_W-1:0] POLY      = 4'b0011,
  parameter int               MAX_BURST = 4
) (
  input logic                    clk,
  input logic                    rst,
  crc_param_faulty_memory_if.slave bus
);
  localparam int CW    = DATA_W + CRC_W;
  localparam int CNT_W = $clog2(CW);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic [2:0] {IDLE, ENC, WRITE, FETCH, CHECK, REPORT} state_t;
  state_t            r_state;
  logic [CW-1:0]     r_mem [DEPTH];
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [CW-1:0]     r_cw;
  logic [CRC_W-1:0]  r_lfsr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_valid;
  logic              r_err;
  logic [DATA_W-1:0] r_rd_data;
  logic [7:0]        r_err_count;
  logic [ADDR_W-1:0] r_last_err_addr;
  logic              w_bit;
  logic [CRC_W-1:0]  w_lfsr_nx;
  logic [CW-1:0]     w_cw_rot;
  logic [CW-1:0]     w_mask;
  int                w_len;
  // data and codeword registers rotate rather than shift, so they are intact after a full pass
  always_comb begin
    w_bit     = r_state == ENC ? r_data[DATA_W-1] : r_cw[CW-1];
    w_lfsr_nx = {r_lfsr[CRC_W-2:0], 1'b0} ^ ((w_bit ^ r_lfsr[CRC_W-1]) ? POLY : '0);
    w_cw_rot  = {r_cw[CW-2:0], r_cw[CW-1]};
    w_len     = int'(bus.burst_len) > MAX_BURST ? MAX_BURST : int'(bus.burst_len);
    w_mask    = '0;
    for (int i = 0; i < CW; i++)
      w_mask[i] = bus.fault_en && i >= int'(bus.fault_pos) && i < int'(bus.fault_pos) + w_len;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= IDLE;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_addr          <= '0;
      r_data          <= '0;
      r_cw            <= '0;
      r_lfsr          <= '0;
      r_cnt           <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_valid         <= 1'b0;
      r_err           <= 1'b0;
      r_rd_data       <= '0;
      r_err_count     <= '0;
      r_last_err_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.wr_req) begin
            r_addr  <= bus.addr_in;
            r_data  <= bus.data_in;
            r_lfsr  <= '0;
            r_cnt   <= CNT_W'(DATA_W - 1);
            r_busy  <= 1'b1;
            r_state <= ENC;
          end else if (bus.rd_req) begin
            r_addr  <= bus.addr_in;
            r_busy  <= 1'b1;
            r_state <= FETCH;
          end
        end
        ENC: begin
          r_lfsr <= w_lfsr_nx;
          r_data <= {r_data[DATA_W-2:0], r_data[DATA_W-1]};
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_done  <= 1'b1;
            r_state <= WRITE;
          end
        end
        WRITE: begin
          r_mem[r_addr] <= {r_data, r_lfsr};
          r_done        <= 1'b0;
          r_busy        <= 1'b0;
          r_state       <= IDLE;
        end
        FETCH: begin
          r_cw    <= r_mem[r_addr] ^ w_mask;
          r_lfsr  <= '0;
          r_cnt   <= CNT_W'(CW - 1);
          r_state <= CHECK;
        end
        CHECK: begin
          r_lfsr <= w_lfsr_nx;
          r_cw   <= w_cw_rot;
          r_cnt  <= r_cnt - 1'b1;
          // results are registered on the last bit so they appear with done
          if (r_cnt == '0) begin
            r_done    <= 1'b1;
            r_rd_data <= w_cw_rot[CW-1:CRC_W];
            r_valid   <= w_lfsr_nx == '0;
            r_err     <= w_lfsr_nx != '0;
            if (w_lfsr_nx != '0) begin
              r_err_count     <= r_err_count + {7'd0, r_err_count != 8'hFF};
              r_last_err_addr <= r_addr;
            end
            r_state <= REPORT;
          end
        end
        REPORT: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.rd_data        = r_rd_data;
  assign bus.data_valid     = r_valid;
  assign bus.error_detected = r_err;
  assign bus.err_count      = r_err_count;
  assign bus.last_err_addr  = r_last_err_addr;
endmodule
